mem_load_unit: RTL
==================

# mem_load_unit

Load-side counterpart of the store merge path: on a load request it reads one 32-bit word from data memory, extracts the word, halfword or byte selected by the load type, extends it to 32 bits and presents the result with a one-cycle `done` pulse. It sits between the control unit and the data memory, feeding the MDR/register-file write-back path. It uses the same lane convention as the store path: halfword in bits [15:0], byte in bits [7:0], with no address-based lane shift.

## Interface
- `MEM_LATENCY`, default 1: cycles from the first `mem_rd` cycle to valid `mem_rdata`. Legal range is 1..15.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: load request, sampled only in IDLE.
- `load_type` input 2: 00 = word, 01 = halfword, 10 = byte, 11 = reserved.
- `unsigned_ld` input 1: 1 = zero-extend (lhu/lbu), 0 = sign-extend. Used only under the macro.
- `addr` input 32: word address to read. Latched at `start`.
- `mem_addr` output 32: address driven to data memory.
- `mem_rd` output 1: memory read strobe.
- `mem_rdata` input 32: memory read data.
- `data_out` output 32: extended load result. Registered and held until the next capture.
- `busy` output 1: high while in READ or DONE.
- `done` output 1: single-cycle result-valid pulse.
- `type_err` output 1: high alongside `done` when the latched `load_type` was 11.

## Operation
- Reset values (asynchronous, immediate):
  - state = IDLE.
  - `mem_rd`, `busy`, `done`, `type_err` = 0.
  - `mem_addr`, `data_out` = 32'h0.
  - wait counter = 0.
- FSM has three states: IDLE, READ, DONE.
- **IDLE**
  - On `start`=1: latch `addr` into `mem_addr`, latch `load_type` and `unsigned_ld`, load counter with MEM_LATENCY-1, and go to READ.
  - Otherwise stay in IDLE.
- **READ**
  - `mem_rd`=1, `busy`=1, `mem_addr` stable.
  - If counter != 0: decrement and stay in READ.
  - If counter == 0: register the extracted `mem_rdata` into `data_out`, set `type_err`, and go to DONE.
- **DONE**
  - `done`=1, `busy`=1, `mem_rd`=0.
  - Unconditionally return to IDLE.
  - `done` and `type_err` fall on leaving DONE.
- Extraction:
  - Word: `data_out` = `mem_rdata`.
  - Half: `data_out` = {16{ext}}, `mem_rdata`[15:0].
  - Byte: `data_out` = {24{ext}}, `mem_rdata`[7:0].
  - Reserved (11): behaves as word; `type_err`=1.
- `start` while `busy` is ignored. It is not queued.
- Input changes on `addr`, `load_type` or `unsigned_ld` after the latch do not affect the operation in flight.
- Reset asserted mid-operation aborts the load: `mem_rd` drops immediately, no `done` is issued, and `data_out` is cleared.

## Timing
- `start` is sampled at edge E0.
- `mem_rd` is high from E0 until E(MEM_LATENCY).
- `mem_rdata` is sampled at edge E(MEM_LATENCY).
- `done` is high for exactly one cycle, between E(MEM_LATENCY) and E(MEM_LATENCY+1).
- Throughput: one load per MEM_LATENCY+2 cycles. A new `start` is accepted at the edge that leaves DONE only if it is asserted in the IDLE cycle that follows.
- `data_out` changes only at the capture edge or on reset.

## Configuration
- `LOAD_SIGNED_EN` defined:
  - ext = `unsigned_ld` ? 0 : sign bit (bit 15 for half, bit 7 for byte).
- `LOAD_SIGNED_EN` undefined:
  - `unsigned_ld` is ignored.
  - ext = 0 always: zero extension only, matching the store path's raw-lane handling.

## Test plan
- Reset mid-READ: assert `reset_n`=0 one cycle after `start` -> `mem_rd`=0 and `data_out`=0 immediately; no `done`; FSM returns to IDLE.
- Word load with MEM_LATENCY=1, `addr`=32'h40, `mem_rdata`=32'hDEADBEEF:
  - `mem_addr`=32'h40 and `mem_rd` high for 1 cycle.
  - `done` on the next cycle with `data_out`=32'hDEADBEEF.
  - `type_err`=0.
- Half load, `mem_rdata`=32'h1234_8001:
  - With the macro and `unsigned_ld`=0: `data_out`=32'hFFFF8001.
  - With `unsigned_ld`=1, or without the macro: `data_out`=32'h00008001.
- Byte load, `mem_rdata`=32'hAABBCC7F, macro on, `unsigned_ld`=0 -> `data_out`=32'h0000007F. Repeat with byte 8'h80 -> 32'hFFFFFF80.
- MEM_LATENCY=4, with `start` re-asserted during READ and `load_type`=11:
  - `mem_rd` is high for exactly 4 cycles.
  - The second `start` is ignored.
  - `done` and `type_err` are both high for 1 cycle.
  - `busy` is high for 5 cycles.

Source files
------------

// File: rtl/mem_load_unit.sv
// Load unit: reads one data-memory word, selects word/half/byte lane and extends it.
// Optional feature macro: LOAD_SIGNED_EN (sign extension selected by unsigned_ld).
module mem_load_unit #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  load_type,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  output logic [31:0] data_out,
  output logic        busy,
  output logic        done,
  output logic        type_err
);

  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [1:0]  lt_q;
  logic        ext_h;
  logic        ext_b;
  logic [31:0] ext_data;

`ifdef LOAD_SIGNED_EN
  logic uns_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      uns_q <= 1'b0;
    else if (state == IDLE && start)
      uns_q <= unsigned_ld;
  end

  assign ext_h = ~uns_q & mem_rdata[15];
  assign ext_b = ~uns_q & mem_rdata[7];
`else
  // Zero extension only; the request's signedness has no effect in this build.
  logic unused_uns;
  assign unused_uns = unsigned_ld;
  assign ext_h      = 1'b0;
  assign ext_b      = 1'b0;
`endif

  always_comb begin
    ext_data = mem_rdata;
    case (lt_q)
      2'b01:   ext_data = {{16{ext_h}}, mem_rdata[15:0]};
      2'b10:   ext_data = {{24{ext_b}}, mem_rdata[7:0]};
      default: ext_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      lt_q     <= '0;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      type_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mem_addr <= addr;
            lt_q     <= load_type;
            cnt      <= CNT_INIT;
            mem_rd   <= 1'b1;
            busy     <= 1'b1;
            state    <= READ;
          end
        end
        READ: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            data_out <= ext_data;
            type_err <= (lt_q == 2'b11);
            mem_rd   <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done     <= 1'b0;
          type_err <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
